fft_uart_tx: RTL and testbench
==============================

Name: fft_uart_tx

Overview:
- Downstream of the FFT controller. Consumes each 2*length-bit result word (cos half in the upper bits, sin half in the lower bits) that the controller presents with a one-cycle valid pulse.
- Serializes the word as consecutive 8N1 UART frames on a single TX line.
- Drives the ready flag that the controller polls before it presents the next word.

Parameters:
- length, 32, width of each half-word; 2*length must be a multiple of 8.
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); must be >= 2.
- NBYTES, 2*length/8 (localparam), bytes per word.

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  reset, asynchronous, active-high.
- i_tx_valid  input  1  one-cycle strobe; i_fft_data is valid.
- i_fft_data  input  2*length  word to transmit.
- o_tx_ready  output  1  high when idle and able to accept a word.
- o_tx  output  1  UART serial line, idle high.
- o_word_done  output  1  one-cycle pulse when the last stop bit of a word completes.

Behaviour:
- Reset (async, all outputs registered): o_tx=1, o_tx_ready=1, o_word_done=0, state=IDLE, all counters=0, shift register=0.
- Reset mid-frame: line returns high immediately and the word is discarded; no partial completion pulse is generated.
- States: IDLE, START, DATA, STOP (plus PARITY when the optional feature is enabled).

Acceptance:
- Acceptance occurs on the edge where state=IDLE and i_tx_valid=1; o_tx_ready is 1 in IDLE.
- On that edge: latch i_fft_data, byte_cnt=0, baud_cnt=0, o_tx_ready<=0, o_tx<=0, state<=START.
- Result: ready is low and the start bit is on the line the cycle after the valid pulse.
- i_tx_valid while not in IDLE is ignored: no queuing, no corruption of the current word.

Bit timing:
- Every bit is held exactly CLKS_PER_BIT cycles. baud_cnt counts 0..CLKS_PER_BIT-1; the bit ends at terminal count.
- START ends -> DATA: o_tx = bit 0 of the current byte, bit_cnt=0.
- DATA advances LSB first. After bit 7 ends -> STOP with o_tx=1.
- STOP end with byte_cnt < NBYTES-1: byte_cnt++, shift the next byte in, state=START, o_tx=0. Back-to-back frames, no idle gap.
- STOP end with byte_cnt = NBYTES-1: state=IDLE, o_tx_ready<=1, o_word_done<=1 for one cycle.

Byte order:
- Most significant byte first: i_fft_data[2*length-1:2*length-8], then downward to [7:0].
- Within a byte, LSB is sent first.

Word duration:
- Acceptance edge to ready-rising edge = NBYTES*10*CLKS_PER_BIT cycles; 80*CLKS_PER_BIT at the default length.
- o_word_done rises on the same edge as o_tx_ready.
- A valid pulse arriving in the cycle where o_word_done=1 is accepted, so words can be sent back-to-back with no idle bit-time.

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined:
  - PARITY state is inserted between DATA bit 7 and STOP.
  - o_tx = XOR of the 8 data bits (even parity), held CLKS_PER_BIT cycles.
  - Word duration becomes NBYTES*11*CLKS_PER_BIT.
- Undefined: 8N1 only; no PARITY state or parity logic is synthesized.

Test Plan (sim with CLKS_PER_BIT=4, length=32):
- Reset then idle 20 cycles -> o_tx=1, o_tx_ready=1, o_word_done=0 throughout.
- Pulse valid with data 64'h0123456789ABCDEF -> o_tx_ready low the next cycle; the decoded bytes are 01,23,45,67,89,AB,CD,EF in that order, each frame 40 cycles; ready and o_word_done rise exactly 320 cycles after acceptance.
- Byte 0x01 check -> line sequence start 0, then data 1,0,0,0,0,0,0,0, then stop 1, each level held 4 cycles.
- Extra valid pulses with other data at 10 and 150 cycles after acceptance -> ignored; the output still matches the first word and only one o_word_done pulse occurs.
- Assert i_rst during byte 3 -> o_tx=1 and o_tx_ready=1 asynchronously, no o_word_done pulse; a new word sent after release transmits correctly.
- With UART_PARITY_EN defined, send 64'hFF00000000000001 -> parity bits are 0, 0, ..., 1 (0xFF even count → 0, 0x01 → 1); word time 352 cycles.

Source files
------------

// File: rtl/fft_uart_tx.sv
// Serializes each 2*length-bit FFT result word as MSB-first 8N1 UART frames.
// Optional even-parity bit per frame when UART_PARITY_EN is defined.
module fft_uart_tx #(
  parameter int unsigned length       = 32,
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_tx_valid,
  input  logic [2*length-1:0] i_fft_data,
  output logic                o_tx_ready,
  output logic                o_tx,
  output logic                o_word_done
);

  localparam int unsigned W      = 2 * length;
  localparam int unsigned NBYTES = W / 8;
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NBYTES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_PARITY_EN
    StParity,
`endif
    StStop
  } state_t;

  state_t            state;
  logic [W-1:0]      shift_reg;
  logic [BAUD_W-1:0] baud_cnt;
  logic [BYTE_W-1:0] byte_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        cur_byte;

  // The byte in flight always sits in the top 8 bits of the shift register.
  assign cur_byte = shift_reg[W-1 -: 8];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= StIdle;
      shift_reg   <= '0;
      baud_cnt    <= '0;
      byte_cnt    <= '0;
      bit_cnt     <= '0;
      o_tx        <= 1'b1;
      o_tx_ready  <= 1'b1;
      o_word_done <= 1'b0;
    end else begin
      o_word_done <= 1'b0;
      if (state == StIdle) begin
        if (i_tx_valid) begin
          shift_reg  <= i_fft_data;
          byte_cnt   <= '0;
          baud_cnt   <= '0;
          bit_cnt    <= '0;
          o_tx_ready <= 1'b0;
          o_tx       <= 1'b0;
          state      <= StStart;
        end
      end else if (baud_cnt != BAUD_LAST) begin
        baud_cnt <= baud_cnt + 1'b1;
      end else begin
        baud_cnt <= '0;
        case (state)
          StStart: begin
            o_tx    <= cur_byte[0];
            bit_cnt <= '0;
            state   <= StData;
          end
          StData: begin
            if (bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
              o_tx  <= ^cur_byte;
              state <= StParity;
`else
              o_tx  <= 1'b1;
              state <= StStop;
`endif
            end else begin
              o_tx    <= cur_byte[bit_cnt + 3'd1];
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
`ifdef UART_PARITY_EN
          StParity: begin
            o_tx  <= 1'b1;
            state <= StStop;
          end
`endif
          StStop: begin
            if (byte_cnt == BYTE_LAST) begin
              o_tx_ready  <= 1'b1;
              o_word_done <= 1'b1;
              state       <= StIdle;
            end else begin
              // Next frame starts immediately, no idle gap between bytes.
              byte_cnt  <= byte_cnt + 1'b1;
              shift_reg <= shift_reg << 8;
              o_tx      <= 1'b0;
              state     <= StStart;
            end
          end
          default: begin
            o_tx       <= 1'b1;
            o_tx_ready <= 1'b1;
            state      <= StIdle;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fft_uart_tx.sv
// Scoreboard bench for fft_uart_tx: expected frames are queued on issue and a
// line decoder pops and compares each received frame.
module tb_fft_uart_tx;

  localparam int unsigned LEN    = 32;
  localparam int unsigned CPB    = 4;
  localparam int unsigned NBYTES = 2 * LEN / 8;
`ifdef UART_PARITY_EN
  localparam int unsigned FB = 11;
`else
  localparam int unsigned FB = 10;
`endif
  localparam int unsigned WORD_CYC = NBYTES * FB * CPB;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_tx_valid = 1'b0;
  logic [2*LEN-1:0]  i_fft_data = '0;
  logic              o_tx_ready;
  logic              o_tx;
  logic              o_word_done;

  int tests_run    = 0;
  int tests_failed = 0;
  int done_cnt     = 0;
  int exp_done     = 0;

  logic [FB-1:0] exp_q[$];

  fft_uart_tx #(
    .length      (LEN),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_tx_valid (i_tx_valid),
    .i_fft_data (i_fft_data),
    .o_tx_ready (o_tx_ready),
    .o_tx       (o_tx),
    .o_word_done(o_word_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame as seen on the line in time order: start, data LSB first, [parity], stop.
  task automatic push_word(input logic [63:0] d);
    logic [7:0] b;
    for (int i = NBYTES - 1; i >= 0; i--) begin
      b = d[8*i +: 8];
`ifdef UART_PARITY_EN
      exp_q.push_back({1'b1, ^b, b, 1'b0});
`else
      exp_q.push_back({1'b1, b, 1'b0});
`endif
    end
    exp_done++;
  endtask

  // Line decoder: every bit must hold the same level for all CPB samples.
  initial begin
    bit            active = 1'b0;
    bit            glitch;
    int            s;
    int            idx;
    logic [FB-1:0] frame;
    logic [FB-1:0] exp;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        active = 1'b0;
      end else if (!active) begin
        if (o_tx == 1'b0) begin
          active = 1'b1;
          s      = 0;
          frame  = '0;
          glitch = 1'b0;
        end
      end else begin
        s++;
        idx = s / CPB;
        if (s % CPB == 0) frame[idx] = o_tx;
        else if (frame[idx] !== o_tx) glitch = 1'b1;
        if (s == FB * CPB - 1) begin
          active = 1'b0;
          if (exp_q.size() == 0) begin
            check("unexpected_frame", {glitch, frame}, 64'hFFFF);
          end else begin
            exp = exp_q.pop_front();
            check("frame", {glitch, frame}, {1'b0, exp});
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge i_clk);
      if (o_word_done === 1'b1) done_cnt++;
    end
  end

  // Sends a word from a negedge with the DUT idle; returns at the negedge where
  // ready is seen again, or after reset is applied at cycle rst_at (if nonzero).
  task automatic run_word(input logic [63:0] d, input bit inject, input int rst_at);
    int n;
    bit did_rst;
    i_tx_valid = 1'b1;
    i_fft_data = d;
    push_word(d);
    @(negedge i_clk);
    i_tx_valid = 1'b0;
    i_fft_data = '0;
    check("ready_low_after_accept", o_tx_ready, 0);
    check("start_bit_on_line", o_tx, 0);
    n       = 0;
    did_rst = 1'b0;
    while (!o_tx_ready && n <= WORD_CYC + 50) begin
      if (rst_at != 0 && n == rst_at) begin
        #1 i_rst = 1'b1;
        #1;
        check("async_rst_tx_high", o_tx, 1);
        check("async_rst_ready_high", o_tx_ready, 1);
        check("async_rst_no_done", o_word_done, 0);
        repeat (3) @(negedge i_clk);
        exp_q.delete();
        exp_done--;
        i_rst   = 1'b0;
        did_rst = 1'b1;
        break;
      end
      @(negedge i_clk);
      n++;
      i_tx_valid = inject && (n == 10 || n == 150);
      i_fft_data = (inject && (n == 10 || n == 150)) ? 64'hFEEDFACE_5555AAAA : '0;
    end
    i_tx_valid = 1'b0;
    i_fft_data = '0;
    if (!did_rst) begin
      check("word_cycles", n, WORD_CYC);
      check("done_with_ready", o_word_done, 1);
      check("queue_drained", exp_q.size(), 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge i_clk);
    check("reset_tx", o_tx, 1);
    check("reset_ready", o_tx_ready, 1);
    check("reset_done", o_word_done, 0);
    i_rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clk);
      check("idle_line", {o_tx, o_tx_ready, o_word_done}, 3'b110);
    end

    // First byte 0x01 exercises the start/1/0.../stop shape; stray valids ignored.
    run_word(64'h0123456789ABCDEF, 1'b1, 0);
    // Valid in the word_done cycle is accepted back-to-back.
    run_word(64'hA55A00FF807EC33C, 1'b0, 0);
    @(negedge i_clk);
    check("done_pulse_one_cycle", o_word_done, 0);
    check("done_count_two_words", done_cnt, exp_done);

    // Reset during byte 3 (cycles 120..159 of the word).
    run_word(64'h1122334455667788, 1'b0, 130);
    repeat (20) begin
      @(negedge i_clk);
      check("post_rst_idle", {o_tx, o_tx_ready, o_word_done}, 3'b110);
    end
    check("no_done_after_rst", done_cnt, exp_done);

    run_word(64'hDEADBEEFCAFEF00D, 1'b0, 0);
    @(negedge i_clk);
    check("done_count_after_rst", done_cnt, exp_done);

`ifdef UART_PARITY_EN
    run_word(64'hFF00000000000001, 1'b0, 0);
    @(negedge i_clk);
    check("done_count_parity", done_cnt, exp_done);
`endif

    repeat (5) @(negedge i_clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
